// File: rtl/fft_frame_loader.sv
// fft_frame_loader: collects real 16-bit samples into two 4-sample ping-pong
// banks and hands each full bank to a 4-point FFT as complex operands
// (real = sample, imag = 0), then waits for completion or a timeout.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   reset        synchronous active-low reset
//   s_data       real sample, two's complement
//   s_valid      s_data valid
//   s_ready      loader can accept s_data (combinational from registered state)
//   in_point0..3 FFT operands, [31:16] real, [15:0] imag
//   fft_en       one-cycle start pulse to the FFT
//   fft_done     FFT completion, level or pulse
//   frame_count  frames completed (wraps)
//   timeout_err  sticky abort flag, cleared only by reset
module fft_frame_loader #(
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] in_point0,
  output logic [31:0] in_point1,
  output logic [31:0] in_point2,
  output logic [31:0] in_point3,
  output logic        fft_en,
  input  logic        fft_done,
  output logic [15:0] frame_count,
  output logic        timeout_err
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TIMEOUT = CW'(DONE_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [0:1][0:3];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    wr_idx;
  logic [CW-1:0] wait_cnt;

  logic          accept_c;
  logic          frame_done_c;
  logic          release_c;
  logic [1:0]    set_c;
  logic [1:0]    clr_c;

  // Ready only when the bank being filled is free; held low during reset.
  assign s_ready      = reset & ~full[wr_bank];
  assign accept_c     = s_valid & s_ready;
  assign frame_done_c = accept_c & (wr_idx == 2'd3);

  // Success and timeout both release the bank; fft_done has priority.
  assign release_c    = (state == WAIT) & (fft_done | (wait_cnt == TIMEOUT));

  // Fill and release always hit different banks, so both masks apply together.
  assign set_c = {frame_done_c & wr_bank, frame_done_c & ~wr_bank};
  assign clr_c = {release_c & rd_bank, release_c & ~rd_bank};

  // Write-side bookkeeping: slot pointer, fill bank and bank-full flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_idx  <= 2'd0;
    end else begin
      if (accept_c) begin
        wr_idx <= wr_idx + 2'd1;  // wraps to slot 0 after slot 3
        if (frame_done_c) begin
          wr_bank <= ~wr_bank;
        end
      end
      full <= (full | set_c) & ~clr_c;
    end
  end

  // Sample storage; contents are only meaningful while marked full.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_bank][wr_idx] <= s_data;
    end
  end

  // Issue/wait controller with registered operand and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      wait_cnt    <= '0;
      in_point0   <= '0;
      in_point1   <= '0;
      in_point2   <= '0;
      in_point3   <= '0;
      fft_en      <= 1'b0;
      frame_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      fft_en <= 1'b0;
      case (state)
        IDLE: begin
          // Operands and the start pulse become visible in the ISSUE cycle.
          if (full[rd_bank]) begin
            state     <= ISSUE;
            fft_en    <= 1'b1;
            in_point0 <= {mem[rd_bank][2'd0], 16'h0000};
            in_point1 <= {mem[rd_bank][2'd1], 16'h0000};
            in_point2 <= {mem[rd_bank][2'd2], 16'h0000};
            in_point3 <= {mem[rd_bank][2'd3], 16'h0000};
          end
        end
        ISSUE: begin
          // fft_done is not looked at here, so a done seen during ISSUE is ignored.
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (release_c) begin
            state   <= IDLE;
            rd_bank <= ~rd_bank;
            if (fft_done) begin
              frame_count <= frame_count + 16'd1;
            end else begin
              timeout_err <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: directed, table-driven bench for fft_frame_loader.
// A vector table covers reset and a basic frame; hand-written sequences cover
// streaming with back-pressure, timeouts, reset mid-frame and counter wrap.
module tb_fft_frame_loader;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] in_point0;
  logic [31:0] in_point1;
  logic [31:0] in_point2;
  logic [31:0] in_point3;
  logic        fft_en;
  logic        fft_done;
  logic [15:0] frame_count;
  logic        timeout_err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fft_frame_loader #(.DONE_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .in_point0   (in_point0),
    .in_point1   (in_point1),
    .in_point2   (in_point2),
    .in_point3   (in_point3),
    .fft_en      (fft_en),
    .fft_done    (fft_done),
    .frame_count (frame_count),
    .timeout_err (timeout_err)
  );

  // Inputs applied before an edge, expected outputs just after it.
  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] dat;
    logic        done;
    logic        e_rdy;
    logic        e_en;
    logic [15:0] e_fc;
    logic        e_to;
    logic [15:0] e_p0;
    logic [15:0] e_p1;
    logic [15:0] e_p2;
    logic [15:0] e_p3;
  } vec_t;

  vec_t        tv [12];
  logic [31:0] pts [3][4];

  function automatic vec_t mk(input logic rst, input logic vld, input logic [15:0] dat,
                              input logic done, input logic e_rdy, input logic e_en,
                              input logic [15:0] e_fc, input logic e_to,
                              input logic [15:0] p0, input logic [15:0] p1,
                              input logic [15:0] p2, input logic [15:0] p3);
    vec_t r;
    r.rst = rst; r.vld = vld; r.dat = dat; r.done = done;
    r.e_rdy = e_rdy; r.e_en = e_en; r.e_fc = e_fc; r.e_to = e_to;
    r.e_p0 = p0; r.e_p1 = p1; r.e_p2 = p2; r.e_p3 = p3;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 16'd0;
    fft_done = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    check("push_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic push4(input logic [15:0] base);
    for (int i = 0; i < 4; i++) push(base + 16'(i));
  endtask

  task automatic check_points(input string name, input logic [15:0] base);
    check({name, "_p0"}, in_point0, {base,          16'h0000});
    check({name, "_p1"}, in_point1, {base + 16'd1,  16'h0000});
    check({name, "_p2"}, in_point2, {base + 16'd2,  16'h0000});
    check({name, "_p3"}, in_point3, {base + 16'd3,  16'h0000});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent;
    int en_cnt;
    int drop_at;
    int first_en;
    int second_en;
    int to_at;
    int en_before_to;
    logic hs;

    reset    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 16'd0;
    fft_done = 1'b0;

    // Reset, no consumption under reset, one frame 1..4 with done 3 cycles after fft_en.
    tv[0]  = mk(0, 0, 16'd0, 0,  0, 0, 16'd0, 0,  16'd0, 16'd0, 16'd0, 16'd0);
    tv[1]  = mk(0, 1, 16'd9, 0,  0, 0, 16'd0, 0,  16'd0, 16'd0, 16'd0, 16'd0);
    tv[2]  = mk(1, 1, 16'd1, 0,  1, 0, 16'd0, 0,  16'd0, 16'd0, 16'd0, 16'd0);
    tv[3]  = mk(1, 1, 16'd2, 0,  1, 0, 16'd0, 0,  16'd0, 16'd0, 16'd0, 16'd0);
    tv[4]  = mk(1, 1, 16'd3, 0,  1, 0, 16'd0, 0,  16'd0, 16'd0, 16'd0, 16'd0);
    tv[5]  = mk(1, 1, 16'd4, 0,  1, 0, 16'd0, 0,  16'd0, 16'd0, 16'd0, 16'd0);
    tv[6]  = mk(1, 0, 16'd0, 0,  1, 1, 16'd0, 0,  16'd1, 16'd2, 16'd3, 16'd4);
    tv[7]  = mk(1, 0, 16'd0, 0,  1, 0, 16'd0, 0,  16'd1, 16'd2, 16'd3, 16'd4);
    tv[8]  = mk(1, 0, 16'd0, 0,  1, 0, 16'd0, 0,  16'd1, 16'd2, 16'd3, 16'd4);
    tv[9]  = mk(1, 0, 16'd0, 0,  1, 0, 16'd0, 0,  16'd1, 16'd2, 16'd3, 16'd4);
    tv[10] = mk(1, 0, 16'd0, 1,  1, 0, 16'd1, 0,  16'd1, 16'd2, 16'd3, 16'd4);
    tv[11] = mk(1, 0, 16'd0, 0,  1, 0, 16'd1, 0,  16'd1, 16'd2, 16'd3, 16'd4);

    for (int i = 0; i < 12; i++) begin
      reset    = tv[i].rst;
      s_valid  = tv[i].vld;
      s_data   = tv[i].dat;
      fft_done = tv[i].done;
      tick();
      check($sformatf("row%0d_ready", i), 32'(s_ready), 32'(tv[i].e_rdy));
      check($sformatf("row%0d_en", i), 32'(fft_en), 32'(tv[i].e_en));
      check($sformatf("row%0d_fc", i), 32'(frame_count), 32'(tv[i].e_fc));
      check($sformatf("row%0d_to", i), 32'(timeout_err), 32'(tv[i].e_to));
      check($sformatf("row%0d_p0", i), in_point0, {tv[i].e_p0, 16'h0000});
      check($sformatf("row%0d_p1", i), in_point1, {tv[i].e_p1, 16'h0000});
      check($sformatf("row%0d_p2", i), in_point2, {tv[i].e_p2, 16'h0000});
      check($sformatf("row%0d_p3", i), in_point3, {tv[i].e_p3, 16'h0000});
    end

    // Stream 12 samples with fft_done held low: back-pressure, timeout, ordered reissue.
    do_reset();
    sent = 0; en_cnt = 0; drop_at = -1; first_en = -1; second_en = -1;
    to_at = -1; en_before_to = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      s_valid = (sent < 12);
      s_data  = 16'(sent + 1);
      hs      = s_valid & s_ready;
      tick();
      if (hs) sent++;
      if (fft_en) begin
        if (en_cnt < 3) begin
          pts[en_cnt][0] = in_point0;
          pts[en_cnt][1] = in_point1;
          pts[en_cnt][2] = in_point2;
          pts[en_cnt][3] = in_point3;
        end
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        else if (second_en < 0) second_en = cyc;
      end
      if (!s_ready && drop_at < 0 && sent < 12) drop_at = sent;
      if (timeout_err && to_at < 0) begin
        to_at = cyc;
        en_before_to = en_cnt;
      end
    end
    s_valid = 1'b0;
    check("stream_drop_after", 32'(drop_at), 32'd8);
    check("stream_en_before_timeout", 32'(en_before_to), 32'd1);
    check("stream_timeout_delay", 32'(to_at - first_en), 32'(TO + 2));
    check("stream_reissue_delay", 32'(second_en - first_en), 32'(TO + 3));
    check("stream_sent", 32'(sent), 32'd12);
    check("stream_en_count", 32'(en_cnt), 32'd3);
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 4; k++)
        check($sformatf("stream_f%0d_p%0d", f, k), pts[f][k], {16'(f * 4 + k + 1), 16'h0000});
    check("stream_fc", 32'(frame_count), 32'd0);
    check("stream_to", 32'(timeout_err), 32'd1);

    // fft_done only during ISSUE is ignored and the timeout path is taken.
    do_reset();
    check("rst_clears_to", 32'(timeout_err), 32'd0);
    push4(16'h0011);
    tick();
    check("issue_only_en", 32'(fft_en), 32'd1);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    to_at = -1;
    for (int k = 1; k <= int'(TO) + 4; k++) begin
      tick();
      if (timeout_err && to_at < 0) to_at = k;
    end
    check("issue_only_to_delay", 32'(to_at), 32'(TO + 1));
    check("issue_only_fc", 32'(frame_count), 32'd0);

    // fft_done exactly on the timeout cycle counts as success.
    do_reset();
    push4(16'h0031);
    tick();
    check("tie_en", 32'(fft_en), 32'd1);
    for (int k = 0; k <= int'(TO); k++) tick();
    check("tie_to_before", 32'(timeout_err), 32'd0);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("tie_fc", 32'(frame_count), 32'd1);
    check("tie_to", 32'(timeout_err), 32'd0);

    // Reset while in WAIT with the other bank partly filled discards everything.
    push4(16'h0041);
    push(16'h0051);
    check("midreset_en", 32'(fft_en), 32'd1);
    push(16'h0052);
    reset = 1'b0;
    tick();
    check("midreset_ready", 32'(s_ready), 32'd0);
    check("midreset_en0", 32'(fft_en), 32'd0);
    check("midreset_fc", 32'(frame_count), 32'd0);
    check("midreset_to", 32'(timeout_err), 32'd0);
    check("midreset_p0", in_point0, 32'd0);
    check("midreset_p3", in_point3, 32'd0);
    reset = 1'b1;
    #1;
    check("release_ready", 32'(s_ready), 32'd1);
    tick();
    check("release_no_en", 32'(fft_en), 32'd0);
    push4(16'h0061);
    tick();
    check("after_reset_en", 32'(fft_en), 32'd1);
    check_points("after_reset", 16'h0061);
    tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("after_reset_fc", 32'(frame_count), 32'd1);

    // Frame counter wrap from 0xFFFF to 0x0000 without a timeout.
    force dut.frame_count = 16'hFFFF;
    tick();
    release dut.frame_count;
    #1;
    check("wrap_preset", 32'(frame_count), 32'h0000FFFF);
    push4(16'h0071);
    tick();
    check("wrap_en", 32'(fft_en), 32'd1);
    check_points("wrap", 16'h0071);
    tick();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("wrap_fc", 32'(frame_count), 32'd0);
    check("wrap_to", 32'(timeout_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
